rng_sequencer: RTL and testbench

RNG_SEQUENCER -- requirements
Module: rng_sequencer

---
 rtl/rng_sequencer.sv | 100 ++++++++++
 tb/tb_rng_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_sequencer.sv
// Sequences an external 128-bit XNOR LFSR: seed load, warm-up discard, then one word per STEPS_PER_WORD steps.
// Latency: seed accept at T -> word at T+2+WARMUP_STEPS+STEPS_PER_WORD; word accept at H -> next word at H+1+STEPS_PER_WORD.
// Backpressure: a word is held (LFSR frozen) until rand_ready; a new seed is accepted only in IDLE or HOLD.
module rng_sequencer #(
    parameter int WARMUP_STEPS = 32,
    parameter int STEPS_PER_WORD = 26,
    parameter logic [127:0] FIXUP_SEED = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         seed_valid,
    input  logic [127:0] seed,
    output logic         seed_ready,
    output logic         lfsr_enable,
    output logic         lfsr_loadSeed,
    output logic [127:0] lfsr_seed,
    input  logic [127:0] lfsr_out,
    output logic         rand_valid,
    input  logic         rand_ready,
    output logic [127:0] rand_data,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, LOAD, WARMUP, GEN, HOLD} state_t;

    localparam logic [7:0] WARM_LAST = 8'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);
    localparam logic [7:0] GEN_LAST  = 8'(STEPS_PER_WORD - 1);

    state_t       state;
    logic [7:0]   step_cnt;
    logic [127:0] seed_reg;
    logic [127:0] seed_fixed;
    logic         seed_fire;
    logic         rand_fire;

    // All-ones is the XNOR lock-up state; every other seed, including zero, is usable.
    assign seed_fixed = (&seed) ? FIXUP_SEED : seed;
    assign seed_fire  = seed_valid && seed_ready;
    assign rand_fire  = rand_valid && rand_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            step_cnt <= 8'd0;
            seed_reg <= 128'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_fire) begin
                        seed_reg <= seed_fixed;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    step_cnt <= 8'd0;
                    state    <= (WARMUP_STEPS == 0) ? GEN : WARMUP;
                end
                WARMUP: begin
                    if (step_cnt == WARM_LAST) begin
                        step_cnt <= 8'd0;
                        state    <= GEN;
                    end else begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                GEN: begin
                    if (step_cnt == GEN_LAST) begin
                        step_cnt <= 8'd0;
                        state    <= HOLD;
                    end else begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (seed_fire) begin
                        seed_reg <= seed_fixed;
                        step_cnt <= 8'd0;
                        state    <= LOAD;
                    end else if (rand_fire) begin
                        step_cnt <= 8'd0;
                        state    <= GEN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates every output so nothing leaks while reset is held, even before the first edge.
    always_comb begin
        seed_ready    = !reset && (state == IDLE || state == HOLD);
        lfsr_enable   = !reset && (state == LOAD || state == WARMUP || state == GEN);
        lfsr_loadSeed = !reset && (state == LOAD);
        lfsr_seed     = reset ? 128'h0 : seed_reg;
        rand_valid    = !reset && (state == HOLD);
        rand_data     = rand_valid ? lfsr_out : 128'h0;
        busy          = !reset && (state != IDLE);
    end

endmodule

// File: tb/tb_rng_sequencer.sv
// Bench for rng_sequencer: default instance plus a WARMUP=0/STEPS=1 instance, each driving a behavioural XNOR LFSR.
module tb_rng_sequencer;

    localparam logic [127:0] FIXUP = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic seed_valid = 1'b0, rand_ready = 1'b0;
    logic [127:0] seed = 128'h0;
    logic seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy;
    logic [127:0] lfsr_seed, lfsr_out, rand_data;

    logic seed_valid2 = 1'b0, rand_ready2 = 1'b0;
    logic [127:0] seed2 = 128'h0;
    logic seed_ready2, lfsr_enable2, lfsr_loadSeed2, rand_valid2, busy2;
    logic [127:0] lfsr_seed2, lfsr_out2, rand_data2;

    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_word;

    always #5 clock = ~clock;

    rng_sequencer dut (
        .clock(clock), .reset(reset), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready), .lfsr_enable(lfsr_enable), .lfsr_loadSeed(lfsr_loadSeed),
        .lfsr_seed(lfsr_seed), .lfsr_out(lfsr_out), .rand_valid(rand_valid),
        .rand_ready(rand_ready), .rand_data(rand_data), .busy(busy)
    );

    rng_sequencer #(.WARMUP_STEPS(0), .STEPS_PER_WORD(1)) dut2 (
        .clock(clock), .reset(reset), .seed_valid(seed_valid2), .seed(seed2),
        .seed_ready(seed_ready2), .lfsr_enable(lfsr_enable2), .lfsr_loadSeed(lfsr_loadSeed2),
        .lfsr_seed(lfsr_seed2), .lfsr_out(lfsr_out2), .rand_valid(rand_valid2),
        .rand_ready(rand_ready2), .rand_data(rand_data2), .busy(busy2)
    );

    // Taps 128,126,101,99 in XNOR form: all-ones maps to itself.
    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        return {s[126:0], ~(s[127] ^ s[125] ^ s[100] ^ s[98])};
    endfunction

    function automatic logic [127:0] lfsr_adv(input logic [127:0] s, input int n);
        logic [127:0] r = s;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    always @(posedge clock) begin
        if (lfsr_enable) lfsr_out <= lfsr_loadSeed ? lfsr_seed : lfsr_next(lfsr_out);
        if (lfsr_enable2) lfsr_out2 <= lfsr_loadSeed2 ? lfsr_seed2 : lfsr_next(lfsr_out2);
    end

    task automatic send_seed(input bit which, input logic [127:0] value);
        @(posedge clock); #1;
        if (which) begin seed_valid2 = 1'b1; seed2 = value; end
        else begin seed_valid = 1'b1; seed = value; end
        @(posedge clock); #1;
        seed_valid = 1'b0;
        seed_valid2 = 1'b0;
    endtask

    // Counts negedges until rand_valid; -1 when the budget runs out.
    task automatic wait_valid(input bit which, output int n);
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (which ? rand_valid2 : rand_valid) return;
            if (n >= 300) begin n = -1; return; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        seed_valid = 1'b1;
        seed = 128'h1234;
        repeat (2) begin
            @(negedge clock);
            total++;
            if ({seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy} !== 5'b0 ||
                lfsr_seed !== 128'h0 || rand_data !== 128'h0) begin
                bad++;
                $display("FAIL reset_outputs got ctl=%b seed=%h data=%h want all zero",
                         {seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy}, lfsr_seed, rand_data);
            end
        end
        @(posedge clock); #1;
        seed_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy} !== 5'b10000 || lfsr_seed !== 128'h0) begin
            bad++;
            $display("FAIL post_reset got ctl=%b seed=%h want ctl=10000 seed=0",
                     {seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy}, lfsr_seed);
        end
    endtask

    task automatic test_latency;
        exp_q.push_back(lfsr_adv(128'h1, 58));
        send_seed(1'b0, 128'h1);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            total++;
            if (lfsr_loadSeed !== (k == 1) || lfsr_enable !== (k <= 59) || rand_valid !== (k == 60) ||
                busy !== 1'b1 || seed_ready !== (k == 60)) begin
                bad++;
                $display("FAIL latency_ctl k=%0d got load=%b en=%b vld=%b busy=%b rdy=%b want load=%b en=%b vld=%b busy=1 rdy=%b",
                         k, lfsr_loadSeed, lfsr_enable, rand_valid, busy, seed_ready,
                         k == 1, k <= 59, k == 60, k == 60);
            end
            if (k == 1) begin
                total++;
                if (lfsr_seed !== 128'h1) begin
                    bad++;
                    $display("FAIL latency_seed got %h want 1", lfsr_seed);
                end
            end
        end
        last_word = exp_q.pop_front();
        total++;
        if (rand_data !== last_word) begin
            bad++;
            $display("FAIL latency_data got %h want %h", rand_data, last_word);
        end
    endtask

    task automatic test_hold;
        int n;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            total++;
            if (rand_valid !== 1'b1 || rand_data !== last_word || lfsr_enable !== 1'b0 || seed_ready !== 1'b1) begin
                bad++;
                $display("FAIL hold k=%0d got vld=%b en=%b rdy=%b data=%h want vld=1 en=0 rdy=1 data=%h",
                         k, rand_valid, lfsr_enable, seed_ready, rand_data, last_word);
            end
        end
        @(posedge clock); #1;
        rand_ready = 1'b1;
        exp_q.push_back(lfsr_adv(last_word, 26));
        @(posedge clock); #1;
        rand_ready = 1'b0;
        @(negedge clock);
        total++;
        if (rand_valid !== 1'b0 || rand_data !== 128'h0 || lfsr_enable !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got vld=%b en=%b data=%h want vld=0 en=1 data=0", rand_valid, lfsr_enable, rand_data);
        end
        wait_valid(1'b0, n);
        total++;
        if (n + 1 !== 27) begin
            bad++;
            $display("FAIL word_to_word got %0d cycles want 27", n + 1);
        end
        last_word = exp_q.pop_front();
        total++;
        if (rand_data !== last_word) begin
            bad++;
            $display("FAIL word_to_word_data got %h want %h", rand_data, last_word);
        end
    endtask

    task automatic test_lockup;
        int n;
        exp_q.push_back(lfsr_adv(FIXUP, 58));
        send_seed(1'b0, {128{1'b1}});
        @(negedge clock);
        total++;
        if (lfsr_loadSeed !== 1'b1 || lfsr_seed !== FIXUP) begin
            bad++;
            $display("FAIL lockup_seed got load=%b seed=%h want load=1 seed=%h", lfsr_loadSeed, lfsr_seed, FIXUP);
        end
        wait_valid(1'b0, n);
        total++;
        if (n !== 59) begin
            bad++;
            $display("FAIL lockup_latency got %0d want 59", n);
        end
        last_word = exp_q.pop_front();
        total++;
        if (rand_data !== last_word || rand_data === {128{1'b1}}) begin
            bad++;
            $display("FAIL lockup_data got %h want %h", rand_data, last_word);
        end
    endtask

    task automatic test_seed_and_rand;
        int n;
        @(posedge clock); #1;
        seed_valid = 1'b1;
        seed = 128'h0;
        rand_ready = 1'b1;
        exp_q.push_back(lfsr_adv(128'h0, 58));
        @(posedge clock); #1;
        seed_valid = 1'b0;
        rand_ready = 1'b0;
        @(negedge clock);
        total++;
        if (lfsr_loadSeed !== 1'b1 || lfsr_seed !== 128'h0 || rand_valid !== 1'b0) begin
            bad++;
            $display("FAIL seed_and_rand got load=%b vld=%b seed=%h want load=1 vld=0 seed=0",
                     lfsr_loadSeed, rand_valid, lfsr_seed);
        end
        wait_valid(1'b0, n);
        total++;
        if (n !== 59) begin
            bad++;
            $display("FAIL seed_and_rand_latency got %0d want 59", n);
        end
        last_word = exp_q.pop_front();
        total++;
        if (rand_data !== last_word) begin
            bad++;
            $display("FAIL seed_and_rand_data got %h want %h", rand_data, last_word);
        end
    endtask

    task automatic test_reset_mid_gen;
        int n;
        send_seed(1'b0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
        repeat (38) @(posedge clock);
        @(negedge clock);
        total++;
        if (lfsr_enable !== 1'b1 || lfsr_loadSeed !== 1'b0 || rand_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_gen_state got en=%b load=%b vld=%b want en=1 load=0 vld=0", lfsr_enable, lfsr_loadSeed, rand_valid);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            total++;
            if ({seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy} !== 5'b0 || lfsr_seed !== 128'h0) begin
                bad++;
                $display("FAIL mid_gen_reset got ctl=%b seed=%h want zero",
                         {seed_ready, lfsr_enable, lfsr_loadSeed, rand_valid, busy}, lfsr_seed);
            end
        end
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 70; k++) begin
            @(negedge clock);
            total++;
            if (seed_ready !== 1'b1 || busy !== 1'b0 || rand_valid !== 1'b0 || lfsr_enable !== 1'b0) begin
                bad++;
                $display("FAIL after_reset_idle k=%0d got rdy=%b busy=%b vld=%b en=%b want 1 0 0 0",
                         k, seed_ready, busy, rand_valid, lfsr_enable);
            end
        end
        exp_q.push_back(lfsr_adv(128'h3, 58));
        send_seed(1'b0, 128'h3);
        wait_valid(1'b0, n);
        total++;
        if (n !== 60) begin
            bad++;
            $display("FAIL reseed_latency got %0d want 60", n);
        end
        last_word = exp_q.pop_front();
        total++;
        if (rand_data !== last_word) begin
            bad++;
            $display("FAIL reseed_data got %h want %h", rand_data, last_word);
        end
        // Drop an unconsumed word with reset.
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (rand_valid !== 1'b0 || rand_data !== 128'h0 || seed_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_reset got vld=%b rdy=%b busy=%b data=%h want vld=0 rdy=1 busy=0 data=0",
                     rand_valid, seed_ready, busy, rand_data);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        exp_q.delete();
        exp_q.push_back(lfsr_adv(128'h5, 1));
        @(posedge clock); #1;
        seed_valid2 = 1'b1;
        seed2 = 128'h5;
        @(posedge clock); #1;
        seed_valid2 = 1'b0;
        rand_ready2 = 1'b1;
        wait_valid(1'b1, n);
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL fast_latency got %0d want 3", n);
        end
        for (int k = 3; k <= 13; k++) begin
            if (k > 3) @(negedge clock);
            total++;
            if (rand_valid2 !== k[0] || busy2 !== 1'b1) begin
                bad++;
                $display("FAIL back_to_back k=%0d got vld=%b busy=%b want vld=%b busy=1", k, rand_valid2, busy2, k[0]);
            end
            if (rand_valid2 && exp_q.size() > 0) begin
                last_word = exp_q.pop_front();
                total++;
                if (rand_data2 !== last_word) begin
                    bad++;
                    $display("FAIL back_to_back_data k=%0d got %h want %h", k, rand_data2, last_word);
                end
                exp_q.push_back(lfsr_adv(last_word, 1));
            end
        end
        @(posedge clock); #1;
        rand_ready2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_hold();
        test_lockup();
        test_seed_and_rand();
        test_reset_mid_gen();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
